// File: rtl/btn_debounce_repeat.sv
// ============================================================================
// Module   : btn_debounce_repeat
// Purpose  : Per-channel push-button synchronizer, debouncer and auto-repeat.
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_debounce_repeat #(
    parameter int N             = 4,
    parameter int DEBOUNCE_CNT  = 1000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic         clk100mhz,
    input  logic         rst,
    input  logic [N-1:0] btn_in,
    input  logic         rpt_en,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic [N-1:0] btn_rpt
);

    localparam int c_DB_W  = $clog2(DEBOUNCE_CNT);
    localparam int c_TMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_TM_W  = $clog2(c_TMAX);

    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [c_TM_W-1:0] c_RD_LAST = c_TM_W'(REPEAT_DELAY - 1);
    localparam logic [c_TM_W-1:0] c_RP_LAST = c_TM_W'(REPEAT_PERIOD - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DELAY  = 2'd1;
    localparam logic [1:0] c_REPEAT = 2'd2;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            logic              r_s1;
            logic              r_s2;
            logic [c_DB_W-1:0] r_cnt;
            logic              r_level;
            logic              r_press;
            logic              r_release;
            logic              r_rpt;
            logic [1:0]        r_state;
            logic [c_TM_W-1:0] r_timer;
            logic              w_flip;
            logic              w_rise;
            logic              w_fall;

            // Level flips on the cycle the stable-differ run reaches DEBOUNCE_CNT.
            assign w_flip = (r_s2 != r_level) && (r_cnt == c_DB_LAST);
            assign w_rise = w_flip &  r_s2;
            assign w_fall = w_flip & ~r_s2;

            always_ff @(posedge clk100mhz) begin
                if (rst) begin
                    r_s1      <= 1'b0;
                    r_s2      <= 1'b0;
                    r_cnt     <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_s1      <= btn_in[gi];
                    r_s2      <= r_s1;
                    r_press   <= w_rise;
                    r_release <= w_fall;
                    if (r_s2 == r_level) begin
                        r_cnt <= '0;
                    end else if (w_flip) begin
                        r_cnt   <= '0;
                        r_level <= r_s2;
                    end else begin
                        r_cnt <= r_cnt + c_DB_W'(1);
                    end
                end
            end

            // Release or a dropped enable wins over a coincident repeat tick.
            always_ff @(posedge clk100mhz) begin
                if (rst) begin
                    r_state <= c_IDLE;
                    r_timer <= '0;
                    r_rpt   <= 1'b0;
                end else begin
                    r_rpt <= w_rise;
                    if (w_fall || !rpt_en) begin
                        r_state <= c_IDLE;
                        r_timer <= '0;
                    end else begin
                        case (r_state)
                            c_IDLE: begin
                                if (w_rise) begin
                                    r_state <= c_DELAY;
                                    r_timer <= '0;
                                end
                            end
                            c_DELAY: begin
                                if (r_timer == c_RD_LAST) begin
                                    r_state <= c_REPEAT;
                                    r_timer <= '0;
                                    r_rpt   <= 1'b1;
                                end else begin
                                    r_timer <= r_timer + c_TM_W'(1);
                                end
                            end
                            c_REPEAT: begin
                                if (r_timer == c_RP_LAST) begin
                                    r_timer <= '0;
                                    r_rpt   <= 1'b1;
                                end else begin
                                    r_timer <= r_timer + c_TM_W'(1);
                                end
                            end
                            default: begin
                                r_state <= c_IDLE;
                                r_timer <= '0;
                            end
                        endcase
                    end
                end
            end

            assign btn_level[gi]   = r_level;
            assign btn_press[gi]   = r_press;
            assign btn_release[gi] = r_release;
            assign btn_rpt[gi]     = r_rpt;
        end
    endgenerate

endmodule

`default_nettype wire

// File: doc/btn_debounce_repeat.md
BTN_DEBOUNCE_REPEAT -- requirements
Module: btn_debounce_repeat

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning the number of independent push-button channels.
REQ-002 The module SHALL have parameter DEBOUNCE_CNT, default 1000000, meaning the consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
REQ-003 The module SHALL have parameter REPEAT_DELAY, default 50000000, meaning the cycles from the press pulse to the first auto-repeat pulse.
REQ-004 The module SHALL have parameter REPEAT_PERIOD, default 10000000, meaning the cycles between subsequent auto-repeat pulses.
REQ-005 The module SHALL have port clk100mhz, input, 1 bit, the single 100 MHz system clock; all logic is clocked on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-007 The module SHALL have port btn_in, input, N bits, raw asynchronous bouncing button levels (1 = pressed).
REQ-008 The module SHALL have port rpt_en, input, 1 bit, a global auto-repeat enable.
REQ-009 The module SHALL have port btn_level, output, N bits, the debounced button levels.
REQ-010 The module SHALL have port btn_press, output, N bits, a one-cycle pulse on each debounced rising edge.
REQ-011 The module SHALL have port btn_release, output, N bits, a one-cycle pulse on each debounced falling edge.
REQ-012 The module SHALL have port btn_rpt, output, N bits, a one-cycle pulse on each press and on each auto-repeat tick.

Function
REQ-013 Each btn_in bit SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-014 Each channel SHALL have a debounce counter: cleared when s2 equals btn_level, incremented when they differ; when it equals DEBOUNCE_CNT-1 and s2 still differs, btn_level SHALL take s2 and the counter SHALL clear.
REQ-015 The btn_level latency SHALL be exactly DEBOUNCE_CNT+2 rising edges, counting as edge 1 the first edge that samples the new btn_in value, provided the input is stable throughout.
REQ-016 Any return of s2 to the current btn_level before the count completes SHALL restart the count from 0; glitches shorter than DEBOUNCE_CNT cycles SHALL produce no output activity.
REQ-017 btn_press[i] SHALL be high for exactly the first cycle in which btn_level[i] is 1, and btn_release[i] for exactly the first cycle in which btn_level[i] is 0 after a 1; all outputs are registered.
REQ-018 Each channel SHALL have an auto-repeat FSM with states IDLE, DELAY and REPEAT, plus a timer.
REQ-019 FSM transition: IDLE to DELAY on press with rpt_en=1, timer cleared.
REQ-020 FSM transition: DELAY to REPEAT when the timer reaches REPEAT_DELAY-1, emitting a btn_rpt pulse and clearing the timer.
REQ-021 FSM behaviour in REPEAT: a btn_rpt pulse every REPEAT_PERIOD cycles.
REQ-022 FSM transition: any state to IDLE on release or when rpt_en=0, timer cleared, with no btn_rpt in that cycle.
REQ-023 With press cycle P, btn_rpt SHALL pulse at P, at P+REPEAT_DELAY, and at P+REPEAT_DELAY+k*REPEAT_PERIOD (k≥1) while the button is held with rpt_en=1.
REQ-024 With rpt_en=0, btn_rpt SHALL equal btn_press.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-026 Counter widths SHALL be $clog2(max count + 1) bits and SHALL never wrap; all three timing parameters SHALL be ≥2.

Reset
REQ-027 While rst=1 at a clock edge, synchronizers, debounce counters, timers, btn_level, btn_press, btn_release and btn_rpt SHALL all become 0 and every FSM SHALL enter IDLE.
REQ-028 A button held through reset SHALL be treated as a new press after rst deasserts: btn_level rises after the REQ-015 latency and btn_press fires once.
REQ-029 Reset asserted mid-DELAY or mid-REPEAT SHALL abort the sequence with no further btn_rpt pulse.

Verification (DEBOUNCE_CNT=4, REPEAT_DELAY=16, REPEAT_PERIOD=6, N=4)
REQ-030 Clean press: btn_in[0] goes 0 to 1 before edge 1 -> btn_level[0]=1 after edge 6, and btn_press[0] and btn_rpt[0] are high for that one cycle only.
REQ-031 Bounce: btn_in[1] toggles every 2 cycles for 20 cycles, then holds 1 -> no output activity during the bounce, then a single press pulse 6 edges after settling.
REQ-032 Hold with rpt_en=1 for 60 cycles after press at P -> btn_rpt at P, P+16, P+22, P+28, ...; on release, one btn_release pulse and no further btn_rpt.
REQ-033 Hold with rpt_en=0 -> exactly one btn_rpt at P; raising rpt_en mid-hold produces no repeat until the next press.
REQ-034 rst pulsed for 1 cycle while channel 2 is in REPEAT with btn_in[2] held -> all outputs 0 on the next cycle, then btn_level[2] returns high 6 edges after rst drops with one new press pulse.
REQ-035 btn_in[2] and btn_in[3] rise on the same cycle -> btn_press[2] and btn_press[3] pulse in the same cycle, and subsequent repeat pulses stay aligned.
